// File: rtl/pipeline_stage_ctrl.sv
// Front-end pipeline control: owns PC, IF/ID and ID/EX registers and applies
// flush/stall requests (flush > stall > advance), with event counters and a stall watchdog.
module pipeline_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = 16,
    parameter int          COUNT_W   = 16,
    parameter int          MAX_STALL = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [31:0]       pc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic              if_id_valid,
    output logic [31:0]       id_ex_instr,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              id_ex_valid,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count,
    output logic              stall_timeout,
    output logic [1:0]        state
);

    localparam int              CS_W     = $clog2(MAX_STALL + 1);
    localparam logic [CS_W-1:0] CS_MAX   = CS_W'(MAX_STALL);
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [1:0]      RUN      = 2'b00;
    localparam logic [1:0]      STALL    = 2'b01;
    localparam logic [1:0]      REDIRECT = 2'b10;

    logic [CS_W-1:0] stall_run;
    logic [CS_W-1:0] stall_run_next;
    logic [31:0]     redirect_pc;

    function automatic logic [COUNT_W-1:0] sat_inc_count(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    function automatic logic [CS_W-1:0] sat_inc_run(input logic [CS_W-1:0] v);
        return (v >= CS_MAX) ? v : v + CS_W'(1);
    endfunction

    // Targets are word aligned; the low two bits of the request are dropped.
    assign redirect_pc    = branch_target & 32'hFFFF_FFFC;
    assign stall_run_next = sat_inc_run(stall_run);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            if_id_instr   <= NOP;
            if_id_pc      <= '0;
            if_id_valid   <= 1'b0;
            id_ex_instr   <= NOP;
            id_ex_ctrl    <= '0;
            id_ex_valid   <= 1'b0;
            stall_count   <= '0;
            flush_count   <= '0;
            stall_timeout <= 1'b0;
            stall_run     <= '0;
            state         <= RUN;
        end else if (flush) begin
            pc          <= redirect_pc;
            if_id_instr <= NOP;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            id_ex_instr <= NOP;
            id_ex_ctrl  <= '0;
            id_ex_valid <= 1'b0;
            flush_count <= sat_inc_count(flush_count);
            stall_run   <= '0;
            state       <= REDIRECT;
        end else if (stall) begin
            // PC and IF/ID hold; a bubble goes down into ID/EX.
            id_ex_instr <= NOP;
            id_ex_ctrl  <= '0;
            id_ex_valid <= 1'b0;
            stall_count <= sat_inc_count(stall_count);
            stall_run   <= stall_run_next;
            if (stall_run_next >= CS_MAX) begin
                stall_timeout <= 1'b1;
            end
            state <= STALL;
        end else begin
            pc          <= pc + 32'd4;
            if_id_instr <= imem_instr;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            id_ex_instr <= if_id_instr;
            id_ex_ctrl  <= if_id_valid ? id_ctrl : '0;
            id_ex_valid <= if_id_valid;
            stall_run   <= '0;
            state       <= RUN;
        end
    end

endmodule

// File: doc/pipeline_stage_ctrl.md
Name: pipeline_stage_ctrl

Overview:
Consumes the stall and flush requests from the hazard-detection and branch-resolution logic and applies them to the front-end pipeline state. It owns the PC register, the IF/ID register and the ID/EX control/instruction register. It inserts bubbles, holds stages and redirects fetch. It also keeps saturating stall/flush event counters and a stuck-stall watchdog.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CTRL_W, 16, width of decoded control bundle carried into ID/EX
COUNT_W, 16, width of stall/flush event counters
MAX_STALL, 8, consecutive stall cycles that trigger stall_timeout (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  load-use stall request from hazard detection
flush  in  1  taken-branch flush request
branch_target  in  32  redirect PC; valid when flush=1
imem_instr  in  32  instruction at current pc (combinational imem read)
id_ctrl  in  CTRL_W  decoded control for instruction in IF/ID
pc  out  32  current fetch PC
if_id_instr  out  32  IF/ID instruction
if_id_pc  out  32  IF/ID PC
if_id_valid  out  1  IF/ID holds a real instruction
id_ex_instr  out  32  ID/EX instruction (feeds forwarding unit)
id_ex_ctrl  out  CTRL_W  ID/EX control; all-zero = bubble
id_ex_valid  out  1  ID/EX holds a real instruction
stall_count  out  COUNT_W  saturating count of stall cycles applied
flush_count  out  COUNT_W  saturating count of flushes applied
stall_timeout  out  1  sticky: stall held MAX_STALL consecutive cycles
state  out  2  00 RUN, 01 STALL, 10 REDIRECT

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high. All state updates occur on the rising edge of clk.
- NOP = 32'h0000_0013 (addi x0,x0,0).
- Reset values:
  - pc=RESET_PC.
  - if_id_instr=NOP, if_id_pc=0, if_id_valid=0.
  - id_ex_instr=NOP, id_ex_ctrl=0, id_ex_valid=0.
  - Both counters 0, stall_timeout=0, state=RUN.
- Reset overrides all inputs, including mid-stall and mid-redirect.
- Per-cycle priority: flush > stall > advance.
- Flush (flush=1, regardless of stall):
  - pc <= {branch_target[31:2],2'b00}.
  - IF/ID <= NOP, pc field 0, valid 0.
  - ID/EX <= bubble: NOP, ctrl 0, valid 0.
  - flush_count++. Consecutive-stall counter cleared.
  - Next state=REDIRECT.
- Stall (stall=1, flush=0):
  - pc and IF/ID hold.
  - ID/EX <= bubble.
  - stall_count++. Consecutive-stall counter++.
  - Next state=STALL.
- Advance (stall=0, flush=0):
  - pc <= pc+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
  - IF/ID <= {imem_instr, pc, valid=1}.
  - ID/EX <= {if_id_instr, id_ctrl, if_id_valid}; id_ctrl is forced to 0 when if_id_valid=0.
  - Consecutive-stall counter cleared. Next state=RUN.
- REDIRECT lasts exactly one cycle unless flush or stall recurs; the behaviour in that cycle is identical to RUN. The state is observable for debug only.
- Counters saturate at all-ones and never wrap.
- Consecutive-stall counter is internal, width ceil(log2(MAX_STALL+1)), and saturating. When it reaches MAX_STALL, stall_timeout is set and stays 1 until rst.
- Stall while if_id_valid=0 is still applied and counted.
- Back-to-back flushes: each one redirects to the new branch_target and counts.
- Outputs are register outputs only. There is no combinational path from inputs to outputs.

Test Plan:
1. Reset then 3 advance cycles, imem_instr=A,B,C -> pc=0x0C; if_id_instr=C, if_id_pc=0x08; id_ex_instr=B, id_ex_valid=1.
2. Stall for 1 cycle after IF/ID=B -> pc and if_id held for that cycle, id_ex_ctrl=0, id_ex_valid=0, stall_count=1. Release stall -> B enters ID/EX.
3. flush=1 with branch_target=0x0000_0103 -> next pc=0x100, if_id_instr=NOP, if_id_valid=0, id_ex_valid=0, flush_count=1, state=REDIRECT, then RUN on the next cycle.
4. stall=1 and flush=1 in the same cycle -> flush behaviour only; stall_count unchanged; consecutive-stall counter cleared.
5. stall held MAX_STALL=8 cycles -> stall_timeout rises on the 8th edge and stays 1 after stall drops. rst -> 0.
6. Force stall_count to all-ones via long stall (COUNT_W=4 build), plus pc wrap from 0xFFFF_FFFC -> count stays 0xF, pc becomes 0.
